// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants, register indices and word/address types.
// Used by the register file, ALU, control and data-memory blocks.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_AT   = 5'd1;
  localparam reg_addr_t REG_V0   = 5'd2;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_reg_file_if.sv
// Register-file access bundle: two read ports plus one write-back port.
// master = datapath side, slave = register file.
interface mips_reg_file_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rs_addr, rt_addr,
    output wr_en, wr_addr, wr_data,
    input  rs_data, rt_data
  );

  modport slave (
    input  rs_addr, rt_addr,
    input  wr_en, wr_addr, wr_data,
    output rs_data, rt_data
  );

endinterface

// File: rtl/mips_rf_read_port.sv
// One combinational register-file read port with r0 masking.
// Optional RF_BYPASS_EN adds same-cycle write-to-read forwarding.
module mips_rf_read_port #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input  logic [ADDR_W-1:0]               addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
`ifdef RF_BYPASS_EN
  input  logic                            byp_ok,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
`endif
  output logic [DATA_W-1:0]               data
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  always_comb begin
    data = '0;
    if (addr != ZERO) begin
      data = regs[addr];
    end
`ifdef RF_BYPASS_EN
    // byp_ok is low in reset so a discarded write is never forwarded
    if (byp_ok && wr_en &&
        (wr_addr != ZERO) &&
        (wr_addr == addr)) begin
      data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS general-purpose register file, r0 hardwired to zero.
// Define RF_BYPASS_EN to forward the write port to both read ports.
module mips_reg_file #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input logic            clk,
  input logic            rst_n,
  mips_reg_file_if.slave rf
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  if (NUM_REGS != (2 ** ADDR_W)) begin : g_bad_cfg
    $error("NUM_REGS must equal 2**ADDR_W");
  end

  // r0 has no storage; the array starts at index 1
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] rf_view;

  always_comb begin
    regs_d = regs_q;
    if (rf.wr_en && (rf.wr_addr != ZERO)) begin
      regs_d[rf.wr_addr] = rf.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rf_view = {regs_q, DATA_W'(0)};

  mips_rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rs_port (
    .addr    (rf.rs_addr),
    .regs    (rf_view),
`ifdef RF_BYPASS_EN
    .byp_ok  (rst_n),
    .wr_en   (rf.wr_en),
    .wr_addr (rf.wr_addr),
    .wr_data (rf.wr_data),
`endif
    .data    (rf.rs_data)
  );

  mips_rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rt_port (
    .addr    (rf.rt_addr),
    .regs    (rf_view),
`ifdef RF_BYPASS_EN
    .byp_ok  (rst_n),
    .wr_en   (rf.wr_en),
    .wr_addr (rf.wr_addr),
    .wr_data (rf.wr_data),
`endif
    .data    (rf.rt_data)
  );

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file using an expected-value queue
// and a shadow register model; honours RF_BYPASS_EN.
module tb_mips_reg_file;

  import mips_pkg::*;

  logic clk;
  logic rst_n;

  mips_reg_file_if rf_if ();

  mips_reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks;
  int    errors;
  word_t exp_q[$];
  word_t model[32];
  word_t exp_v;
  word_t got_v;

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic do_write(input reg_addr_t a, input word_t d);
    @(negedge clk);
    rf_if.wr_en   = 1'b1;
    rf_if.wr_addr = a;
    rf_if.wr_data = d;
    @(posedge clk);
    if (rst_n && a != REG_ZERO) model[a] = d;
    #1;
    rf_if.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) begin
      rf_if.rs_addr = reg_addr_t'(i);
      rf_if.rt_addr = reg_addr_t'(31 - i);
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front();
      got_v = rf_if.rs_data;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_rs[%0d]: got %h expected %h", i, got_v, exp_v);
      end
      exp_v = exp_q.pop_front();
      got_v = rf_if.rt_data;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_rt[%0d]: got %h expected %h", 31 - i, got_v, exp_v);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_write(5'd8, 32'h0000_0014);
    do_write(5'd9, 32'h0000_0003);
    @(negedge clk);
    rf_if.rs_addr = 5'd8;
    rf_if.rt_addr = 5'd9;
    exp_q.push_back(32'h0000_0014);
    exp_q.push_back(32'h0000_0003);
    exp_q.push_back(32'h0000_0017);
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL basic_rs8: got %h expected %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front();
    got_v = rf_if.rt_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL basic_rt9: got %h expected %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data + rf_if.rt_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL basic_add: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_reg_zero();
    do_write(REG_ZERO, 32'hFFFF_FFFF);
    @(negedge clk);
    rf_if.rs_addr = REG_ZERO;
    rf_if.rt_addr = REG_ZERO;
    exp_q.push_back('0);
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL zero_rs: got %h expected %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front();
    got_v = rf_if.rt_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL zero_rt: got %h expected %h", got_v, exp_v);
    end
    for (int i = 1; i < 32; i++) begin
      rf_if.rs_addr = reg_addr_t'(i);
      rf_if.rt_addr = reg_addr_t'(i);
      exp_q.push_back(model[i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rf_if.rs_data !== exp_v || rf_if.rt_data !== exp_v) begin
        errors++;
        $display("FAIL zero_side[%0d]: got %h/%h expected %h",
                 i, rf_if.rs_data, rf_if.rt_data, exp_v);
      end
    end
  endtask

  task automatic test_wr_en_gating();
    @(negedge clk);
    rf_if.wr_en   = 1'b0;
    rf_if.wr_addr = 5'd10;
    rf_if.wr_data = 32'h1234_5678;
    rf_if.rs_addr = 5'd10;
    exp_q.push_back(32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL wr_en_gate: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_same_cycle();
    do_write(REG_RA, 32'h0040_0000);
    @(negedge clk);
    rf_if.rs_addr = REG_RA;
    rf_if.rt_addr = REG_RA;
    rf_if.wr_en   = 1'b1;
    rf_if.wr_addr = REG_RA;
    rf_if.wr_data = 32'h0040_0008;
`ifdef RF_BYPASS_EN
    exp_q.push_back(32'h0040_0008);
`else
    exp_q.push_back(32'h0040_0000);
`endif
    exp_q.push_back(32'h0040_0008);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rf_if.rs_data !== exp_v || rf_if.rt_data !== exp_v) begin
      errors++;
      $display("FAIL same_cycle_pre: got %h/%h expected %h",
               rf_if.rs_data, rf_if.rt_data, exp_v);
    end
    @(posedge clk);
    model[31] = 32'h0040_0008;
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL same_cycle_post: got %h expected %h", got_v, exp_v);
    end
    rf_if.wr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    reg_addr_t addrs[4];
    word_t     vals[4];
    addrs = '{REG_AT, REG_V0, REG_SP, 5'd17};
    for (int i = 0; i < 4; i++) begin
      vals[i] = word_t'($urandom);
      do_write(addrs[i], vals[i]);
    end
    for (int i = 0; i < 4; i++) begin
      rf_if.rs_addr = addrs[i];
      rf_if.rt_addr = addrs[3 - i];
      exp_q.push_back(vals[i]);
      exp_q.push_back(vals[3 - i]);
      #1;
      exp_v = exp_q.pop_front();
      got_v = rf_if.rs_data;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_rs[%0d]: got %h expected %h", addrs[i], got_v, exp_v);
      end
      exp_v = exp_q.pop_front();
      got_v = rf_if.rt_data;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_rt[%0d]: got %h expected %h", addrs[3 - i], got_v, exp_v);
      end
    end
  endtask

  task automatic test_write_during_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    rf_if.wr_en   = 1'b1;
    rf_if.wr_addr = 5'd4;
    rf_if.wr_data = 32'hA5A5_A5A5;
    rf_if.rs_addr = 5'd4;
    rf_if.rt_addr = 5'd4;
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rf_if.rs_data !== exp_v || rf_if.rt_data !== exp_v) begin
      errors++;
      $display("FAIL rst_write_during: got %h/%h expected %h",
               rf_if.rs_data, rf_if.rt_data, exp_v);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf_if.wr_en = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back('0);
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rst_write_release: got %h expected %h", got_v, exp_v);
    end
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rt_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rst_write_after_edge: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd5, 32'hDEAD_BEEF);
    do_write(REG_RA, 32'h0040_0008);
    rf_if.rs_addr = 5'd5;
    rf_if.rt_addr = REG_RA;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back('0);
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL async_pre: got %h expected %h", got_v, exp_v);
    end
    rst_n = 1'b0;
    clear_model();
    #1;
    exp_v = exp_q.pop_front();
    got_v = rf_if.rs_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL async_rs5: got %h expected %h", got_v, exp_v);
    end
    exp_v = exp_q.pop_front();
    got_v = rf_if.rt_data;
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL async_rt31: got %h expected %h", got_v, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    rf_if.rs_addr = '0;
    rf_if.rt_addr = '0;
    rf_if.wr_en   = 1'b0;
    rf_if.wr_addr = '0;
    rf_if.wr_data = '0;
    clear_model();

    test_reset();
    test_basic();
    test_reg_zero();
    test_wr_en_gating();
    test_same_cycle();
    test_back_to_back();
    test_write_during_reset();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
